serial_to_parallel: RTL and testbench

Serial-in, parallel-out deserializer. It is the receive-side counterpart of the team's parallel-load serial shifter: it collects BUS_WIDTH serial bits, MSB-first or LSB-first, into a word. Completed words are presented on a one-entry output buffer with a valid/ready handshake. The block sits between a serial link and a word-wide consumer.

---
 rtl/serial_to_parallel_pkg.sv | 13 +
 rtl/s2p_out_buf.sv | 53 +++++
 rtl/serial_to_parallel.sv | 102 ++++++++++
 tb/tb_serial_to_parallel.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_pkg.sv
// Shared encodings for the serial-to-parallel receiver.
// The direction values match the serializer's i_sht_lr port.
package serial_to_parallel_pkg;

  localparam logic DIR_RIGHT = 1'b1;  // LSB-first
  localparam logic DIR_LEFT  = 1'b0;  // MSB-first

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } s2p_state_e;

endpackage

// File: rtl/s2p_out_buf.sv
// One-entry valid/ready holding register with a sticky drop flag.
// A word arriving while the entry is full and not being consumed is dropped.
module s2p_out_buf
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr_ovf,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overflow;
  logic             w_space;

  // Consumption in the same cycle frees the entry, so a new word loads without a bubble.
  assign w_space = ~r_valid | i_ready;

  // NOTE: the data register is reset as well, because o_reg_data must read 0 straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (i_load && w_space) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_clr_ovf)
        r_overflow <= 1'b0;
      else if (i_load && !w_space)
        r_overflow <= 1'b1;
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-in, parallel-out deserializer, MSB-first or LSB-first.
// Completed words go to a one-entry valid/ready output buffer.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter  int BUS_WIDTH = 32,
  localparam int CNT_W     = $clog2(BUS_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_shift,
  input  logic                 i_shift_data,
  input  logic                 i_sht_lr,
  output logic [BUS_WIDTH-1:0] o_reg_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_overflow
);

  s2p_state_e           r_state, w_state_next;
  logic [CNT_W-1:0]     r_count, w_count_next;
  logic [BUS_WIDTH-1:0] r_sreg, w_sreg_next, w_shifted;
  logic                 r_dir, w_dir_next;
  logic                 w_dir_cur;
  logic                 w_done;

  // The direction is taken live on the first bit and from the latch for the rest.
  assign w_dir_cur = (r_state == ST_IDLE) ? i_sht_lr : r_dir;
  assign w_shifted = (w_dir_cur == DIR_RIGHT) ? {i_shift_data, r_sreg[BUS_WIDTH-1:1]}
                                              : {r_sreg[BUS_WIDTH-2:0], i_shift_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_sreg  <= '0;
      r_dir   <= DIR_LEFT;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sreg  <= w_sreg_next;
      r_dir   <= w_dir_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_sreg_next  = r_sreg;
    w_dir_next   = r_dir;
    w_done       = 1'b0;

    if (i_start) begin
      // Start wins over a coincident bit; the partial word is discarded.
      w_state_next = ST_IDLE;
      w_count_next = '0;
      w_sreg_next  = '0;
    end else if (i_shift) begin
      w_sreg_next = w_shifted;
      unique case (r_state)
        ST_IDLE: begin
          w_dir_next   = i_sht_lr;
          w_state_next = ST_SHIFT;
          w_count_next = CNT_W'(1);
        end
        ST_SHIFT: begin
          if (r_count == CNT_W'(BUS_WIDTH - 1)) begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end
      endcase
    end
  end

  assign o_busy = (r_count != '0);

  s2p_out_buf #(
    .WIDTH(BUS_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_done),
    .i_data    (w_shifted),
    .i_clr_ovf (i_start),
    .i_ready   (i_ready),
    .o_data    (o_reg_data),
    .o_valid   (o_valid),
    .o_overflow(o_overflow)
  );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel at BUS_WIDTH=8.
// Expected words are queued as streams are sent and popped on each handshake.
module tb_serial_to_parallel;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_shift = 1'b0;
  logic         i_shift_data = 1'b0;
  logic         i_sht_lr = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_reg_data;
  logic         o_valid;
  logic         o_busy;
  logic         o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] sb_q[$];

  serial_to_parallel #(.BUS_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_shift     (i_shift),
    .i_shift_data(i_shift_data),
    .i_sht_lr    (i_sht_lr),
    .o_reg_data  (o_reg_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: stream bits s[7]..s[0]; LSB-first places the first bit at bit 0.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] s, input logic lsb_first);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      r[i] = lsb_first ? s[W-1-i] : s[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [W-1:0] s, input int n, input logic lr, input logic toggle);
    for (int i = 0; i < n; i++) begin
      i_shift      = 1'b1;
      i_shift_data = s[W-1-i];
      i_sht_lr     = toggle ? (lr ^ logic'(i % 2)) : lr;
      tick();
    end
    i_shift = 1'b0;
  endtask

  // Handshake monitor: a word is consumed at the edge after valid & ready is seen.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      logic [W-1:0] exp_w;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got word %h, expected no word", o_reg_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (o_reg_data !== exp_w) begin
          n_fail++;
          $display("FAIL sb_word: got %h, expected %h", o_reg_data, exp_w);
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    n_tests++;
    if ({o_reg_data, o_valid, o_busy, o_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b b=%b o=%b, expected all 0",
               o_reg_data, o_valid, o_busy, o_overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_msb_first();
    logic [W-1:0] s = 8'h35;
    i_ready = 1'b1;
    sb_q.push_back(model_word(s, 1'b0));
    for (int i = 0; i < W; i++) begin
      i_shift = 1'b1; i_shift_data = s[W-1-i]; i_sht_lr = 1'b0;
      tick();
      n_tests++;
      if (o_busy !== (i < W - 1)) begin
        n_fail++;
        $display("FAIL msb_busy bit%0d: got %b, expected %b", i + 1, o_busy, (i < W - 1));
      end
    end
    i_shift = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_reg_data !== 8'h35) begin
      n_fail++;
      $display("FAIL msb_word: got v=%b data=%h, expected v=1 data=35", o_valid, o_reg_data);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_valid_pulse: got v=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_lsb_first();
    sb_q.push_back(model_word(8'h35, 1'b1));
    shift_bits(8'h35, W, 1'b1, 1'b0);
    n_tests++;
    if (o_reg_data !== 8'hAC) begin
      n_fail++;
      $display("FAIL lsb_word: got %h, expected ac", o_reg_data);
    end
    tick();
    sb_q.push_back(model_word(8'h35, 1'b1));
    shift_bits(8'h35, W, 1'b1, 1'b1);
    n_tests++;
    if (o_reg_data !== 8'hAC) begin
      n_fail++;
      $display("FAIL lsb_dir_latched: got %h, expected ac", o_reg_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    i_ready = 1'b0;
    sb_q.push_back(8'h35);
    shift_bits(8'h35, W, 1'b0, 1'b0);
    shift_bits(8'h5A, W, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (o_reg_data !== 8'h35 || o_valid !== 1'b1 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: got data=%h v=%b o=%b, expected 35 1 1", o_reg_data, o_valid, o_overflow);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_tests++;
    if (o_overflow !== 1'b0 || o_reg_data !== 8'h35 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear: got data=%h v=%b o=%b, expected 35 1 0", o_reg_data, o_valid, o_overflow);
    end
    i_ready = 1'b1;
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain: got v=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    sb_q.push_back(8'h35);
    sb_q.push_back(8'hC3);
    shift_bits(8'h35, W, 1'b0, 1'b0);
    shift_bits(8'hC3, W - 1, 1'b0, 1'b0);
    i_shift = 1'b1; i_shift_data = 1'b1; i_ready = 1'b1;
    tick();
    i_shift = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_reg_data !== 8'hC3 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load: got data=%h v=%b o=%b, expected c3 1 0", o_reg_data, o_valid, o_overflow);
    end
    tick();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_start_abort();
    i_ready = 1'b1;
    shift_bits(8'hFF, 4, 1'b0, 1'b0);
    n_tests++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got %b, expected 1", o_busy);
    end
    i_start = 1'b1; i_shift = 1'b1; i_shift_data = 1'b1;
    tick();
    i_start = 1'b0; i_shift = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || dut.r_count !== '0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b count=%0d v=%b, expected 0 0 0", o_busy, dut.r_count, o_valid);
    end
    sb_q.push_back(8'hF0);
    shift_bits(8'hF0, W, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1 || o_reg_data !== 8'hF0) begin
      n_fail++;
      $display("FAIL abort_next_word: got v=%b data=%h, expected 1 f0", o_valid, o_reg_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    sb_q.push_back(8'h35);
    shift_bits(8'h35, W, 1'b0, 1'b0);
    shift_bits(8'h5A, W, 1'b0, 1'b0);
    shift_bits(8'hE0, 3, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_setup: got v=%b b=%b o=%b, expected 1 1 1", o_valid, o_busy, o_overflow);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_reg_data, o_valid, o_busy, o_overflow} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: got data=%h v=%b b=%b o=%b, expected all 0",
               o_reg_data, o_valid, o_busy, o_overflow);
    end
    sb_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    i_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overflow();
    test_back_to_back();
    test_start_abort();
    test_async_reset();
    tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending words, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
